dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-side memory target: local word RAM plus an MMIO page (TX FIFO, cycle counter, halt flag).
// Optional sticky bus error reporting is enabled by defining DMEM_RESP_ERR_EN.
module dmem_responder #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt
`ifdef DMEM_RESP_ERR_EN
    ,
    output logic        bus_err
`endif
);

    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

    // Address decode; byte offset bits never participate.
    logic          ram_sel;
    logic          mmio_sel;
    logic [1:0]    mmio_reg;
    logic [AW-1:0] ram_idx;
    logic          unused_addr_bits;

    assign ram_sel          = ({1'b0, daddr} < RAM_BYTES);
    assign mmio_sel         = (daddr[31:4] == MMIO_BASE[31:4]);
    assign mmio_reg         = daddr[3:2];
    assign ram_idx          = daddr[AW+1:2];
    assign unused_addr_bits = ^daddr[1:0];

    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (!reset && ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (dwe[i]) ram[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
            end
        end
    end

    // TX FIFO: a push into a full FIFO is still accepted when the head pops in the same cycle.
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push_ok;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign tx_data  = fifo_mem[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    assign push_req = mmio_sel && (mmio_reg == 2'd0) && dwe[0];
    assign push_ok  = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= dwdata[7:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
            if (push_req && !push_ok) ovf <= 1'b1;
        end
    end

    logic [31:0] cycle_cnt;
    logic        cycle_wr;
    logic        halt_wr;

    assign cycle_wr = mmio_sel && (mmio_reg == 2'd2) && (dwe != 4'h0);
    assign halt_wr  = mmio_sel && (mmio_reg == 2'd3) && (dwe != 4'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= 32'h0;
            halt      <= 1'b0;
        end else begin
            cycle_cnt <= cycle_wr ? 32'h0 : cycle_cnt + 32'h1;
            if (halt_wr) halt <= 1'b1;
        end
    end

    logic err_bit;

`ifdef DMEM_RESP_ERR_EN
    logic unmapped;
    logic partial_mmio;

    assign unmapped     = !ram_sel && !mmio_sel;
    assign partial_mmio = mmio_sel && (mmio_reg != 2'd0) && (dwe != 4'h0) && (dwe != 4'hF);

    always_ff @(posedge clk) begin
        if (reset)                         bus_err <= 1'b0;
        else if (unmapped || partial_mmio) bus_err <= 1'b1;
    end

    assign err_bit = bus_err;
`else
    assign err_bit = 1'b0;
`endif

    logic [7:0] count8;
    assign count8 = 8'(count);

    always_comb begin
        drdata = 32'h0;
        if (ram_sel) begin
            drdata = ram[ram_idx];
        end else if (mmio_sel) begin
            case (mmio_reg)
                2'd0:    drdata = 32'h0;
                2'd1:    drdata = {16'h0, count8, 4'h0, err_bit, ovf, empty, full};
                2'd2:    drdata = cycle_cnt;
                default: drdata = {31'h0, halt};
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder against a queue-based reference model.
module tb_dmem_responder;

    localparam int          RAM_WORDS  = 1024;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;

    logic        clk;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;

    dmem_responder #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MMIO_BASE (MMIO_BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .daddr   (daddr),
        .dwdata  (dwdata),
        .dwe     (dwe),
        .drdata  (drdata),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .halt    (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] ram_m [int];
    logic [7:0]  fifo_q [$];
    logic        ovf_m;
    logic [31:0] cyc_m;
    logic        halt_m;

    logic [31:0] last_rd;
    logic [7:0]  last_txd;
    logic        last_txv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_m();
        logic [7:0] cnt;
        cnt = 8'(fifo_q.size());
        return {16'h0, cnt, 4'h0, 1'b0, ovf_m, fifo_q.size() == 0, fifo_q.size() == FIFO_DEPTH};
    endfunction

    task automatic do_reset(input int n);
        reset    = 1'b1;
        daddr    = 32'h0;
        dwdata   = 32'h0;
        dwe      = 4'h0;
        tx_ready = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        fifo_q.delete();
        ovf_m  = 1'b0;
        cyc_m  = 32'h0;
        halt_m = 1'b0;
    endtask

    // One bus cycle: drive, check combinational outputs against the model, advance model and clock.
    task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                         input logic rdy);
        logic [31:0] exp_rd;
        logic        known;
        logic        is_ram;
        logic        is_mmio;
        logic [1:0]  off;
        int          w;
        logic        do_pop;
        logic        do_push;

        daddr    = a;
        dwdata   = wd;
        dwe      = we;
        tx_ready = rdy;
        #2;

        is_ram  = (a < RAM_WORDS * 4);
        is_mmio = (a[31:4] == MMIO_BASE[31:4]);
        off     = a[3:2];
        w       = int'(a >> 2);
        known   = 1'b1;
        exp_rd  = 32'h0;
        if (is_ram) begin
            if (ram_m.exists(w)) exp_rd = ram_m[w];
            else known = 1'b0;
        end else if (is_mmio) begin
            case (off)
                2'd0:    exp_rd = 32'h0;
                2'd1:    exp_rd = status_m();
                2'd2:    exp_rd = cyc_m;
                default: exp_rd = {31'h0, halt_m};
            endcase
        end

        last_rd  = drdata;
        last_txd = tx_data;
        last_txv = tx_valid;
        if (known) check("drdata", drdata, exp_rd);
        check("tx_valid", {31'h0, tx_valid}, {31'h0, fifo_q.size() != 0});
        check("halt", {31'h0, halt}, {31'h0, halt_m});
        if (fifo_q.size() != 0) check("tx_data", {24'h0, tx_data}, {24'h0, fifo_q[0]});

        if (is_ram) begin
            if (ram_m.exists(w)) begin
                for (int i = 0; i < 4; i++) if (we[i]) ram_m[w][8*i +: 8] = wd[8*i +: 8];
            end else if (we == 4'hF) begin
                ram_m[w] = wd;
            end
        end
        do_pop  = (fifo_q.size() != 0) && rdy;
        do_push = is_mmio && (off == 2'd0) && we[0];
        if (do_push && fifo_q.size() == FIFO_DEPTH && !do_pop) ovf_m = 1'b1;
        else if (do_push) begin
            if (do_pop) void'(fifo_q.pop_front());
            fifo_q.push_back(wd[7:0]);
        end else if (do_pop) void'(fifo_q.pop_front());
        cyc_m = (is_mmio && off == 2'd2 && we != 4'h0) ? 32'h0 : cyc_m + 32'h1;
        if (is_mmio && off == 2'd3 && we != 4'h0) halt_m = 1'b1;

        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  we;
        logic [1:0]  lb;
        int          op;

        do_reset(2);

        // Reset state
        cycle(MMIO_BASE + 32'h4, 32'h0, 4'h0, 1'b0);
        check("reset_status", last_rd, 32'h0000_0002);
        check("reset_txv", {31'h0, last_txv}, 32'h0);
        cycle(MMIO_BASE + 32'hC, 32'h0, 4'h0, 1'b0);
        check("reset_halt", last_rd, 32'h0);

        // RAM byte write
        cycle(32'h10, 32'hAABB_CCDD, 4'hF, 1'b0);
        cycle(32'h10, 32'h0000_00EE, 4'b0100, 1'b0);
        cycle(32'h10, 32'h0, 4'h0, 1'b0);
        check("ram_lane2", last_rd, 32'hAA00_CCDD);
        cycle(32'h12, 32'h0, 4'h0, 1'b0);
        check("ram_misaligned", last_rd, 32'hAA00_CCDD);

        // FIFO fill and overflow
        for (int i = 1; i <= 9; i++) cycle(MMIO_BASE, 32'(i), 4'b0001, 1'b0);
        cycle(MMIO_BASE + 32'h4, 32'h0, 4'h0, 1'b0);
        check("full_status", last_rd, 32'h0000_0805);
        check("full_head", {24'h0, last_txd}, 32'h01);
        cycle(MMIO_BASE, 32'h0, 4'h0, 1'b0);
        check("txdata_read", last_rd, 32'h0);

        // Drain order
        for (int i = 1; i <= 8; i++) begin
            cycle(MMIO_BASE + 32'h4, 32'h0, 4'h0, 1'b1);
            check("drain_byte", {24'h0, last_txd}, 32'(i));
        end
        cycle(MMIO_BASE + 32'h4, 32'h0, 4'h0, 1'b1);
        check("drained_status", last_rd, 32'h0000_0006);
        check("drained_txv", {31'h0, last_txv}, 32'h0);

        // Push and pop together while full
        do_reset(1);
        for (int i = 0; i < 8; i++) cycle(MMIO_BASE, 32'h10 + 32'(i), 4'hF, 1'b0);
        cycle(MMIO_BASE, 32'h55, 4'b0001, 1'b1);
        cycle(MMIO_BASE + 32'h4, 32'h0, 4'h0, 1'b0);
        check("pushpop_status", last_rd, 32'h0000_0801);
        for (int i = 0; i < 8; i++) begin
            cycle(MMIO_BASE + 32'h4, 32'h0, 4'h0, 1'b1);
            check("pushpop_byte", {24'h0, last_txd}, (i == 7) ? 32'h55 : 32'h11 + 32'(i));
        end

        // Counter and halt
        cycle(MMIO_BASE + 32'h8, 32'hFFFF_FFFF, 4'b0010, 1'b0);
        repeat (5) cycle(32'h10, 32'h0, 4'h0, 1'b0);
        cycle(MMIO_BASE + 32'h8, 32'h0, 4'h0, 1'b0);
        check("cycle_five", last_rd, 32'h5);
        cycle(MMIO_BASE + 32'hC, 32'h0, 4'b1000, 1'b0);
        cycle(MMIO_BASE + 32'hC, 32'h0, 4'h0, 1'b0);
        check("halt_set", last_rd, 32'h1);
        repeat (3) cycle(32'h10, 32'h0, 4'h0, 1'b0);
        check("halt_sticky", {31'h0, halt}, 32'h1);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) cycle(MMIO_BASE, 32'hA0 + 32'(i), 4'h1, 1'b0);
        do_reset(1);
        cycle(MMIO_BASE + 32'h8, 32'h0, 4'h0, 1'b0);
        check("rst_cycle", last_rd, 32'h0);
        check("rst_txv", {31'h0, last_txv}, 32'h0);
        cycle(MMIO_BASE + 32'h4, 32'h0, 4'h0, 1'b0);
        check("rst_status", last_rd, 32'h0000_0002);
        cycle(MMIO_BASE + 32'hC, 32'h0, 4'h0, 1'b0);
        check("rst_halt", last_rd, 32'h0);
        cycle(32'h10, 32'h0, 4'h0, 1'b0);
        check("rst_ram", last_rd, 32'hAA00_CCDD);

        // Randomized mix against the model
        for (int i = 0; i < 16; i++) cycle(32'(i * 4), $urandom, 4'hF, 1'b0);
        for (int n = 0; n < 600; n++) begin
            op = $urandom_range(0, 9);
            lb = 2'($urandom);
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            case (op)
                0, 1, 2: a = {26'h0, 4'($urandom_range(0, 15)), lb};
                3, 4:    begin a = MMIO_BASE | {30'h0, lb}; we = 4'($urandom); end
                5:       a = MMIO_BASE | {28'h0, 2'd1, lb};
                6:       begin
                    a  = MMIO_BASE | {28'h0, 2'd2, lb};
                    we = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h0;
                end
                7:       begin a = MMIO_BASE | {28'h0, 2'd3, lb}; we = 4'h0; end
                8:       a = 32'h0010_0000 | 32'($urandom_range(0, 16'hFFFF));
                default: begin a = 32'h10; we = 4'h0; end
            endcase
            cycle(a, $urandom, we, $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
